// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes and EX-slot type for the operand fetch stage
//
// Contents:
//   DATA_W / REG_CNT / ADDR_W : operand width, register count, register index width
//   OP_*                      : 4-bit ALU opcode encodings
//   ex_slot_t                 : bookkeeping carried alongside the registered operands
//   op_uses_carry()           : opcodes that consume the carry-in

package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
    localparam int ADDR_W  = 5;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD   = 4'b0000;
    localparam alu_op_t OP_ADDC  = 4'b0001;
    localparam alu_op_t OP_SUB   = 4'b0010;
    localparam alu_op_t OP_SUBB  = 4'b0011;
    localparam alu_op_t OP_SUBR  = 4'b0100;
    localparam alu_op_t OP_OR    = 4'b0101;
    localparam alu_op_t OP_XOR   = 4'b0110;
    localparam alu_op_t OP_AND   = 4'b0111;
    localparam alu_op_t OP_PASSA = 4'b1000;
    localparam alu_op_t OP_ADD8  = 4'b1001;
    localparam alu_op_t OP_PASSB = 4'b1010;

    // State of the instruction sitting in EX; the operands themselves live
    // in separate registers because they drive the ALU directly.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              sets_c;
    } ex_slot_t;

    function automatic logic op_uses_carry(input alu_op_t op);
        return (op == OP_ADDC) || (op == OP_SUBB);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - decode/EX/WB signal bundle of the operand fetch stage
//
// Groups:
//   decode offer : id_valid, id_ready, id_rs1, id_rs2, id_rd, id_we, id_op,
//                  id_use_imm, id_imm, id_sets_c
//   downstream   : ex_stall, flush, alu_out, alu_c
//   writeback    : wb_we, wb_rd, wb_data
//   ALU inputs   : A, B, Ci, OP (registered)
//   EX slot      : ex_valid, ex_rd, ex_we, ex_sets_c
// Modports:
//   master : the surrounding pipeline (decode, ALU, writeback)
//   slave  : the operand fetch stage

interface operand_fetch_stage_if;

    import alu_pkg::*;

    logic                 id_valid;
    logic                 id_ready;
    logic [ADDR_W-1:0]    id_rs1;
    logic [ADDR_W-1:0]    id_rs2;
    logic [ADDR_W-1:0]    id_rd;
    logic                 id_we;
    alu_op_t              id_op;
    logic                 id_use_imm;
    logic [DATA_W-1:0]    id_imm;
    logic                 id_sets_c;

    logic                 ex_stall;
    logic                 flush;
    logic [DATA_W-1:0]    alu_out;
    logic                 alu_c;

    logic                 wb_we;
    logic [ADDR_W-1:0]    wb_rd;
    logic [DATA_W-1:0]    wb_data;

    logic [DATA_W-1:0]    A;
    logic [DATA_W-1:0]    B;
    logic                 Ci;
    alu_op_t              OP;
    logic                 ex_valid;
    logic [ADDR_W-1:0]    ex_rd;
    logic                 ex_we;
    logic                 ex_sets_c;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_we, id_op,
               id_use_imm, id_imm, id_sets_c,
               ex_stall, flush, alu_out, alu_c,
               wb_we, wb_rd, wb_data,
        input  id_ready, A, B, Ci, OP, ex_valid, ex_rd, ex_we, ex_sets_c
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_op,
               id_use_imm, id_imm, id_sets_c,
               ex_stall, flush, alu_out, alu_c,
               wb_we, wb_rd, wb_data,
        output id_ready, A, B, Ci, OP, ex_valid, ex_rd, ex_we, ex_sets_c
    );

endinterface

// File: rtl/operand_fetch_stage_register_file.sv
// rtl/operand_fetch_stage_register_file.sv - general register file, 2 async reads, 1 sync write
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset (clears every register)
//   ra1, ra2       : read indices
//   rd1, rd2       : read data; r0 reads 0, a same-cycle write to the index reads through
//   we, wa, wd     : write enable, index, data; writes to r0 are dropped

module register_file
    import alu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RC = REG_CNT,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] regs [RC];
    logic          wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RC; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Write-through lets an instruction offered in the writeback cycle see
    // the value being retired instead of the stale entry.
    assign rd1 = (ra1 == '0)             ? '0 :
                 (wr_en && (wa == ra1))  ? wd : regs[ra1];
    assign rd2 = (ra2 == '0)             ? '0 :
                 (wr_en && (wa == ra2))  ? wd : regs[ra2];

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - ID-to-EX operand stage: register read, forwarding, ALU input registers
//
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : operand_fetch_stage_if.slave
//           decode offer (id_*), stall/flush and ALU result (ex_stall, flush,
//           alu_out, alu_c), writeback (wb_*), registered ALU inputs (A, B,
//           Ci, OP) and EX slot state (ex_valid, ex_rd, ex_we, ex_sets_c)
//
// Holds the register file and the PSW carry. Operands resolve with priority
// EX result > writeback data > register file, r0 always zero.

module operand_fetch_stage
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus
);

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              c_fwd;
    logic              advance;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              ci_q;
    alu_op_t           op_q;
    ex_slot_t          ex_q;
    logic              psw_c;

    // WB forwarding and r0 zeroing are handled inside the register file.
    register_file #(
        .DW (DATA_W),
        .RC (REG_CNT),
        .AW (ADDR_W)
    ) u_register_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (bus.id_rs1),
        .ra2   (bus.id_rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (bus.wb_we),
        .wa    (bus.wb_rd),
        .wd    (bus.wb_data)
    );

    // EX forwarding sits on top of the file result so it wins over WB.
    always_comb begin
        opa = rf_rd1;
        if ((bus.id_rs1 != '0) && ex_q.valid && ex_q.we && (ex_q.rd == bus.id_rs1)) begin
            opa = bus.alu_out;
        end

        opb = rf_rd2;
        if (bus.id_use_imm) begin
            opb = bus.id_imm;
        end else if ((bus.id_rs2 != '0) && ex_q.valid && ex_q.we && (ex_q.rd == bus.id_rs2)) begin
            opb = bus.alu_out;
        end
    end

    assign c_fwd   = (ex_q.valid && ex_q.sets_c) ? bus.alu_c : psw_c;
    assign advance = !bus.ex_stall || bus.flush;

    assign bus.id_ready = !bus.ex_stall && !reset;

    // Flush outranks stall; a stall freezes the whole EX slot; otherwise an
    // offer is captured and an empty cycle becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            ci_q <= 1'b0;
            op_q <= OP_ADD;
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q.valid  <= 1'b0;
            ex_q.we     <= 1'b0;
            ex_q.sets_c <= 1'b0;
        end else if (!bus.ex_stall) begin
            if (bus.id_valid) begin
                a_q         <= opa;
                b_q         <= opb;
                ci_q        <= c_fwd;
                op_q        <= bus.id_op;
                ex_q.valid  <= 1'b1;
                ex_q.rd     <= bus.id_rd;
                ex_q.we     <= bus.id_we;
                ex_q.sets_c <= bus.id_sets_c;
            end else begin
                ex_q.valid <= 1'b0;
                ex_q.we    <= 1'b0;
            end
        end
    end

    // The EX instruction commits its carry only when it leaves EX; leaving
    // through a flush still counts, since flush squashes the slot behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            psw_c <= 1'b0;
        end else if (ex_q.valid && ex_q.sets_c && advance) begin
            psw_c <= bus.alu_c;
        end
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Ci        = ci_q;
    assign bus.OP        = op_q;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.ex_rd     = ex_q.rd;
    assign bus.ex_we     = ex_q.we;
    assign bus.ex_sets_c = ex_q.sets_c;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - scoreboard bench for operand_fetch_stage

module tb_operand_fetch_stage;

    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    operand_fetch_stage_if bus();

    operand_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        sc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_regs [32];
    logic        m_psw, m_ev, m_ewe, m_esc, m_ci;
    logic [4:0]  m_erd;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;

    function automatic logic [31:0] fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (m_ev && m_ewe && m_erd == rs) return bus.alu_out;
        if (bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
        return m_regs[rs];
    endfunction

    task automatic set_idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_we = 0; bus.id_op = 0; bus.id_use_imm = 0; bus.id_imm = 0;
        bus.id_sets_c = 0; bus.ex_stall = 0; bus.flush = 0;
        bus.alu_out = 0; bus.alu_c = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [3:0] op, input logic use_imm,
                         input logic [31:0] imm, input logic sets_c);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_we = we; bus.id_op = op; bus.id_use_imm = use_imm; bus.id_imm = imm;
        bus.id_sets_c = sets_c;
    endtask

    // One clock: predict from the current inputs, push on transfer, step, pop and compare.
    task automatic cycle();
        logic xfer;
        exp_t e, got;
        e = '0;
        #1;
        total++;
        if (bus.id_ready !== (!bus.ex_stall && !reset)) begin
            bad++;
            $display("FAIL id_ready got=%b exp=%b", bus.id_ready, !bus.ex_stall && !reset);
        end
        xfer = bus.id_valid && !bus.ex_stall && !bus.flush && !reset;
        if (xfer) begin
            e.a  = fwd(bus.id_rs1);
            e.b  = bus.id_use_imm ? bus.id_imm : fwd(bus.id_rs2);
            e.ci = (m_ev && m_esc) ? bus.alu_c : m_psw;
            e.op = bus.id_op; e.rd = bus.id_rd; e.we = bus.id_we; e.sc = bus.id_sets_c;
            sb.push_back(e);
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_psw = 0; m_ev = 0; m_ewe = 0; m_esc = 0; m_erd = 0;
            m_a = 0; m_b = 0; m_ci = 0; m_op = 0;
            sb.delete();
        end else begin
            if (m_ev && m_esc && (!bus.ex_stall || bus.flush)) m_psw = bus.alu_c;
            if (bus.wb_we && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] = bus.wb_data;
            if (bus.flush) begin
                m_ev = 0; m_ewe = 0; m_esc = 0;
            end else if (!bus.ex_stall) begin
                if (bus.id_valid) begin
                    m_ev = 1; m_a = e.a; m_b = e.b; m_ci = e.ci; m_op = e.op;
                    m_erd = e.rd; m_ewe = e.we; m_esc = e.sc;
                end else begin
                    m_ev = 0; m_ewe = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (xfer && sb.size() > 0) begin
            e   = sb.pop_front();
            got = {bus.A, bus.B, bus.Ci, bus.OP, bus.ex_rd, bus.ex_we, bus.ex_sets_c};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL capture got=%h exp=%h", got, e);
            end
        end
        total++;
        if ({bus.ex_valid, bus.ex_we, bus.A, bus.B, bus.Ci, bus.OP} !== {m_ev, m_ewe, m_a, m_b, m_ci, m_op}) begin
            bad++;
            $display("FAIL ex_state got=%h exp=%h", {bus.ex_valid, bus.ex_we, bus.A, bus.B, bus.Ci, bus.OP},
                     {m_ev, m_ewe, m_a, m_b, m_ci, m_op});
        end
        total++;
        if (dut.psw_c !== m_psw) begin
            bad++;
            $display("FAIL psw_c got=%b exp=%b", dut.psw_c, m_psw);
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        bus.id_valid = 1;
        cycle();
        cycle();
        total++;
        if ({bus.A, bus.B, bus.Ci, bus.OP, bus.ex_valid, bus.ex_rd, bus.ex_we, bus.ex_sets_c} !== 76'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", {bus.A, bus.B, bus.Ci, bus.OP, bus.ex_valid, bus.ex_rd, bus.ex_we, bus.ex_sets_c});
        end
        total++;
        if (bus.id_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_id_ready got=%b exp=0", bus.id_ready);
        end
        reset = 0;
        set_idle();
    endtask

    task automatic test_r0();
        set_idle(); offer(5'd0, 5'd5, 5'd1, 0, OP_ADD, 0, 0, 0);
        cycle();
        total++;
        if ({bus.A, bus.B, bus.Ci, bus.ex_valid} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL r0_first got=%h exp=%h", {bus.A, bus.B, bus.Ci, bus.ex_valid}, {32'd0, 32'd0, 1'b0, 1'b1});
        end
        set_idle(); offer(5'd0, 5'd0, 5'd0, 0, OP_PASSA, 0, 0, 0);
        bus.wb_we = 1; bus.wb_rd = 0; bus.wb_data = 32'hFFFFFFFF;
        cycle();
        total++;
        if (bus.A !== 32'd0) begin bad++; $display("FAIL r0_wb_same got=%h exp=0", bus.A); end
        set_idle(); offer(5'd0, 5'd0, 5'd0, 0, OP_PASSA, 0, 0, 0);
        cycle();
        total++;
        if (bus.A !== 32'd0) begin bad++; $display("FAIL r0_read got=%h exp=0", bus.A); end
    endtask

    task automatic test_wb_forward();
        set_idle(); offer(5'd3, 5'd0, 5'd0, 0, OP_PASSA, 0, 0, 0);
        bus.wb_we = 1; bus.wb_rd = 3; bus.wb_data = 32'h00001234;
        cycle();
        total++;
        if (bus.A !== 32'h00001234) begin bad++; $display("FAIL wb_through got=%h exp=00001234", bus.A); end
        set_idle(); offer(5'd3, 5'd0, 5'd0, 0, OP_PASSA, 0, 0, 0);
        cycle();
        total++;
        if (bus.A !== 32'h00001234) begin bad++; $display("FAIL wb_stored got=%h exp=00001234", bus.A); end
    endtask

    task automatic test_ex_forward();
        set_idle(); offer(5'd0, 5'd0, 5'd4, 1, OP_ADD, 0, 0, 0);
        cycle();
        set_idle(); offer(5'd0, 5'd4, 5'd0, 0, OP_PASSB, 0, 0, 0);
        bus.alu_out = 32'h9C000038;
        bus.wb_we = 1; bus.wb_rd = 4; bus.wb_data = 32'h00000001;
        cycle();
        total++;
        if (bus.B !== 32'h9C000038) begin bad++; $display("FAIL ex_over_wb got=%h exp=9c000038", bus.B); end
        set_idle(); offer(5'd0, 5'd4, 5'd0, 0, OP_PASSB, 0, 0, 0);
        cycle();
        total++;
        if (bus.B !== 32'h00000001) begin bad++; $display("FAIL ex_drained got=%h exp=00000001", bus.B); end
        set_idle(); offer(5'd0, 5'd4, 5'd0, 0, OP_PASSB, 0, 0, 0);
        bus.wb_we = 1; bus.wb_rd = 4; bus.wb_data = 32'h9C000038;
        cycle();
        total++;
        if (bus.B !== 32'h9C000038) begin bad++; $display("FAIL ex_late_wb got=%h exp=9c000038", bus.B); end
    endtask

    task automatic test_carry();
        set_idle(); offer(5'd1, 5'd2, 5'd0, 0, OP_ADD, 0, 0, 1);
        cycle();
        set_idle(); offer(5'd1, 5'd2, 5'd0, 0, OP_ADDC, 0, 0, 0);
        bus.alu_c = 1;
        cycle();
        total++;
        if ({bus.Ci, dut.psw_c} !== 2'b11) begin
            bad++; $display("FAIL carry_fwd got=%b exp=11", {bus.Ci, dut.psw_c});
        end
        set_idle(); offer(5'd1, 5'd2, 5'd0, 0, OP_SUBB, 0, 0, 0);
        cycle();
        total++;
        if (bus.Ci !== 1'b1) begin bad++; $display("FAIL carry_psw got=%b exp=1", bus.Ci); end
    endtask

    task automatic test_stall();
        set_idle(); offer(5'd3, 5'd0, 5'd0, 0, OP_OR, 1, 32'hAA, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_idle(); offer(5'd4, 5'd0, 5'd0, 0, OP_XOR, 1, 32'h77, 0);
            bus.ex_stall = 1;
            bus.alu_c = 0;
            #1;
            total++;
            if (bus.id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", bus.id_ready); end
            cycle();
            total++;
            if ({bus.A, bus.B, bus.OP, bus.ex_valid, dut.psw_c} !== {32'h1234, 32'hAA, OP_OR, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold got=%h exp=%h", {bus.A, bus.B, bus.OP, bus.ex_valid, dut.psw_c},
                         {32'h1234, 32'hAA, OP_OR, 1'b1, 1'b1});
            end
        end
        bus.ex_stall = 0;
        cycle();
        total++;
        if ({bus.A, bus.B, bus.OP, dut.psw_c} !== {32'h9C000038, 32'h77, OP_XOR, 1'b0}) begin
            bad++;
            $display("FAIL stall_release got=%h exp=%h", {bus.A, bus.B, bus.OP, dut.psw_c},
                     {32'h9C000038, 32'h77, OP_XOR, 1'b0});
        end
    endtask

    task automatic test_flush();
        set_idle(); offer(5'd3, 5'd0, 5'd0, 0, OP_ADD, 1, 32'h70000003, 0);
        bus.flush = 1;
        cycle();
        total++;
        if ({bus.ex_valid, bus.A, bus.B} !== {1'b0, 32'h9C000038, 32'h77}) begin
            bad++;
            $display("FAIL flush_squash got=%h exp=%h", {bus.ex_valid, bus.A, bus.B}, {1'b0, 32'h9C000038, 32'h77});
        end
        bus.flush = 0;
        cycle();
        total++;
        if ({bus.ex_valid, bus.B} !== {1'b1, 32'h70000003}) begin
            bad++; $display("FAIL flush_reoffer got=%h exp=%h", {bus.ex_valid, bus.B}, {1'b1, 32'h70000003});
        end
        bus.flush = 1; bus.ex_stall = 1;
        cycle();
        total++;
        if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", bus.ex_valid); end
        set_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            set_idle();
            if ($urandom_range(3) != 0)
                offer(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom),
                      4'($urandom_range(10)), ($urandom_range(3) == 0), $urandom, 1'($urandom));
            bus.ex_stall = ($urandom_range(4) == 0);
            bus.flush    = ($urandom_range(9) == 0);
            bus.alu_out  = $urandom;
            bus.alu_c    = 1'($urandom);
            bus.wb_we    = 1'($urandom);
            bus.wb_rd    = 5'($urandom_range(7));
            bus.wb_data  = $urandom;
            cycle();
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        set_idle(); offer(5'd3, 5'd0, 5'd2, 1, OP_ADD, 0, 0, 1);
        cycle();
        reset = 1;
        cycle();
        total++;
        if ({bus.ex_valid, bus.A} !== 33'd0) begin
            bad++; $display("FAIL reset_mid got=%h exp=0", {bus.ex_valid, bus.A});
        end
        reset = 0;
        set_idle(); offer(5'd3, 5'd0, 5'd0, 0, OP_PASSA, 0, 0, 0);
        cycle();
        total++;
        if (bus.A !== 32'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", bus.A); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_r0();
        test_wb_forward();
        test_ex_forward();
        test_carry();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
